// File: rtl/accel_pkg.sv
// Shared types for the accelerator datapath and the compute arbiter.
package accel_pkg;

    localparam int UNIT_COUNT    = 4;
    localparam int UNIT_ID_WIDTH = $clog2(UNIT_COUNT);
    localparam int MAT_DIM       = 2;
    localparam int ELEM_WIDTH    = 8;
    localparam int ACC_WIDTH     = 16;

    typedef logic [MAT_DIM-1:0][MAT_DIM-1:0][ELEM_WIDTH-1:0] matrix_t;
    typedef logic [MAT_DIM-1:0][ACC_WIDTH-1:0]               vector_t;

    typedef enum logic [1:0] {
        COMP_ADD,
        COMP_MUL,
        COMP_DOT,
        COMP_SCALE
    } comp_type_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/compute_arbiter_picker.sv
// Round-robin priority picker: first set request bit scanning from ptr upward,
// wrapping modulo N. Purely combinational.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Walk the ring once starting at ptr; the first hit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IDX_W'(pos);
            if (!any && req[pos_idx]) begin
                any            = 1'b1;
                grant[pos_idx] = 1'b1;
                idx            = pos_idx;
            end
        end
    end

endmodule

// File: rtl/compute_arbiter.sv
// Round-robin arbiter that serialises compute requests from several units onto
// the single shared compute unit and routes each result back to its owner.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no transaction; pick a winner among req_valid
// ARB_ISSUE | cu_request high, waiting for cu_ready handshake
// ARB_WAIT  | handshake done, waiting for cu_done
// ARB_RESP  | one-cycle rsp_valid pulse to owner, advance rr pointer
module compute_arbiter
    import accel_pkg::*;
#(
    parameter int NUM_REQ        = UNIT_COUNT,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  comp_type_e               req_type [NUM_REQ],
    input  matrix_t                  req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic                     rsp_err,
    output vector_t                  rsp_data,
    output logic                     cu_request,
    output logic [UNIT_ID_WIDTH-1:0] cu_unit_id,
    output comp_type_e               cu_comp_type,
    output matrix_t                  cu_data,
    input  logic                     cu_ready,
    input  logic                     cu_done,
    input  vector_t                  cu_result,
    output logic                     busy,
    output logic                     timeout_flag
);

    localparam int ID_W = UNIT_ID_WIDTH;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e         state, state_n;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_n;
    logic [TW-1:0]      timer, timer_n;
    logic               timed_out;

    logic [NUM_REQ-1:0] req_ready_n, rsp_valid_n;
    logic               rsp_err_n, cu_request_n, busy_n, timeout_flag_n;
    vector_t            rsp_data_n;
    logic [ID_W-1:0]    cu_unit_id_n;
    comp_type_e         cu_comp_type_n;
    matrix_t            cu_data_n;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;

    rr_priority_picker #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign timed_out = (timer == TW'(TIMEOUT_CYCLES));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_n        = state;
        rr_ptr_n       = rr_ptr;
        timer_n        = timer;
        req_ready_n    = '0;
        rsp_valid_n    = '0;
        rsp_err_n      = 1'b0;
        rsp_data_n     = rsp_data;
        cu_request_n   = 1'b0;
        cu_unit_id_n   = cu_unit_id;
        cu_comp_type_n = cu_comp_type;
        cu_data_n      = cu_data;
        timeout_flag_n = timeout_flag;

        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_n        = ARB_ISSUE;
                    req_ready_n    = pick_grant;
                    cu_unit_id_n   = pick_idx;
                    cu_comp_type_n = req_type[pick_idx];
                    cu_data_n      = req_data[pick_idx];
                    cu_request_n   = 1'b1;
                    timer_n        = '0;
                end
            end
            ARB_ISSUE: begin
                timer_n = timer + 1'b1;
                // Timeout wins over a coincident handshake so the abort is final.
                if (timed_out) begin
                    state_n        = ARB_RESP;
                    timeout_flag_n = 1'b1;
                    rsp_valid_n    = NUM_REQ'(1) << cu_unit_id;
                    rsp_err_n      = 1'b1;
                    rsp_data_n     = '0;
                end else if (cu_ready) begin
                    state_n = ARB_WAIT;
                end else begin
                    cu_request_n = 1'b1;
                end
            end
            ARB_WAIT: begin
                timer_n = timer + 1'b1;
                if (timed_out) begin
                    state_n        = ARB_RESP;
                    timeout_flag_n = 1'b1;
                    rsp_valid_n    = NUM_REQ'(1) << cu_unit_id;
                    rsp_err_n      = 1'b1;
                    rsp_data_n     = '0;
                end else if (cu_done) begin
                    state_n     = ARB_RESP;
                    rsp_valid_n = NUM_REQ'(1) << cu_unit_id;
                    rsp_data_n  = cu_result;
                end
            end
            ARB_RESP: begin
                state_n = ARB_IDLE;
                if (int'(cu_unit_id) == NUM_REQ - 1) begin
                    rr_ptr_n = '0;
                end else begin
                    rr_ptr_n = cu_unit_id + 1'b1;
                end
            end
            default: begin
                state_n = ARB_IDLE;
            end
        endcase

        busy_n = (state_n != ARB_IDLE);
    end

    // FSM state, round-robin pointer and timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            timer  <= '0;
        end else begin
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            timer  <= timer_n;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
            cu_request   <= 1'b0;
            cu_unit_id   <= '0;
            cu_comp_type <= COMP_ADD;
            cu_data      <= '0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            req_ready    <= req_ready_n;
            rsp_valid    <= rsp_valid_n;
            rsp_err      <= rsp_err_n;
            rsp_data     <= rsp_data_n;
            cu_request   <= cu_request_n;
            cu_unit_id   <= cu_unit_id_n;
            cu_comp_type <= cu_comp_type_n;
            cu_data      <= cu_data_n;
            busy         <= busy_n;
            timeout_flag <= timeout_flag_n;
        end
    end

endmodule
